// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state enum, size/sign codes and decode helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2,
        SZ_BAD  = 2'd3
    } lsu_size_e;

    // {signed, h, b} encodings
    localparam logic [2:0] CODE_WORD  = 3'b000;
    localparam logic [2:0] CODE_SHALF = 3'b110;
    localparam logic [2:0] CODE_SBYTE = 3'b101;
    localparam logic [2:0] CODE_UHALF = 3'b010;
    localparam logic [2:0] CODE_UBYTE = 3'b001;

    // Stores look only at {h,b}; loads must match one of the five codes exactly.
    function automatic lsu_size_e decode_size(input logic is_load, input logic [2:0] code);
        lsu_size_e size;
        size = SZ_BAD;
        if (is_load) begin
            case (code)
                CODE_WORD:              size = SZ_WORD;
                CODE_SHALF, CODE_UHALF: size = SZ_HALF;
                CODE_SBYTE, CODE_UBYTE: size = SZ_BYTE;
                default:                size = SZ_BAD;
            endcase
        end else begin
            case (code[1:0])
                2'b00:   size = SZ_WORD;
                2'b10:   size = SZ_HALF;
                2'b01:   size = SZ_BYTE;
                default: size = SZ_BAD;
            endcase
        end
        return size;
    endfunction

    // An illegal code counts as misaligned so both are rejected the same way.
    function automatic logic is_rejected(input lsu_size_e size, input logic [1:0] lo);
        logic rej;
        case (size)
            SZ_BAD:  rej = 1'b1;
            SZ_HALF: rej = lo[0];
            SZ_WORD: rej = |lo;
            default: rej = 1'b0;
        endcase
        return rej;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - memory request/response bus between the load/store unit and data memory
interface load_store_unit_if #(
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 32
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_LEN-1:0] mem_req_addr;
    logic                mem_req_we;
    logic [3:0]          mem_req_wstrb;
    logic [WIDTH-1:0]    mem_req_wdata;
    logic                mem_resp_valid;
    logic [WIDTH-1:0]    mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed byte/half lane of a load word and sign/zero extends it
module load_extend
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       code,
    output logic [WIDTH-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select then extend; code[2] is the signed flag
    always_comb begin
        byte_lane = word[{addr_lo, 3'b000} +: 8];
        half_lane = word[{addr_lo[1], 4'b0000} +: 16];
        case (decode_size(1'b1, code))
            SZ_BYTE: data = {{(WIDTH-8){code[2] & byte_lane[7]}}, byte_lane};
            SZ_HALF: data = {{(WIDTH-16){code[2] & half_lane[15]}}, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit: IDLE -> REQ -> WAIT -> DONE
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                ex_ls,
    input  logic                ex_signed,
    input  logic                ex_h,
    input  logic                ex_b,
    input  logic [ADDR_LEN-1:0] ex_addr,
    input  logic [WIDTH-1:0]    ex_wdata,
    load_store_unit_if.master   mem,
    output logic                wb_valid,
    output logic [WIDTH-1:0]    dmem_result,
    output logic                misalign
);

    lsu_state_e          state_q, state_d;
    logic                ls_q, ls_d;
    logic [2:0]          code_q, code_d;
    logic [1:0]          lo_q, lo_d;
    logic                req_valid_q, req_valid_d;
    logic                req_we_q, req_we_d;
    logic [3:0]          req_wstrb_q, req_wstrb_d;
    logic [ADDR_LEN-1:0] req_addr_q, req_addr_d;
    logic [WIDTH-1:0]    req_wdata_q, req_wdata_d;
    logic                wb_valid_q, wb_valid_d;
    logic                misalign_q, misalign_d;
    logic [WIDTH-1:0]    result_q, result_d;

    logic [2:0]          ex_code;
    lsu_size_e           ex_size;
    logic                ex_rej;
    logic [3:0]          st_strb;
    logic [WIDTH-1:0]    st_data;
    logic [WIDTH-1:0]    ext_data;

    assign ex_code = {ex_signed, ex_h, ex_b};
    assign ex_size = decode_size(ex_ls, ex_code);
    assign ex_rej  = is_rejected(ex_size, ex_addr[1:0]);

    load_extend #(.WIDTH(WIDTH)) u_extend (
        .word    (mem.mem_resp_data),
        .addr_lo (lo_q),
        .code    (code_q),
        .data    (ext_data)
    );

    // Replicate store data across lanes so memory can pick it up under any strobe
    always_comb begin
        st_strb = 4'b1111;
        st_data = ex_wdata;
        case (ex_size)
            SZ_BYTE: begin
                st_strb = 4'b0001 << ex_addr[1:0];
                st_data = {(WIDTH/8){ex_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_strb = ex_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {(WIDTH/16){ex_wdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = ex_wdata;
            end
        endcase
        if (ex_ls) begin
            st_strb = 4'b0000;
            st_data = '0;
        end
    end

    // Next-state and next-output computation for the op sequencer
    always_comb begin
        state_d     = state_q;
        ls_d        = ls_q;
        code_d      = code_q;
        lo_d        = lo_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_wstrb_d = req_wstrb_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        wb_valid_d  = 1'b0;
        misalign_d  = misalign_q;
        result_d    = result_q;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    ls_d   = ex_ls;
                    code_d = ex_code;
                    lo_d   = ex_addr[1:0];
                    if (ex_rej) begin
                        state_d    = DONE;
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b1;
                        result_d   = '0;
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_we_d    = ~ex_ls;
                        req_wstrb_d = st_strb;
                        req_addr_d  = {ex_addr[ADDR_LEN-1:2], 2'b00};
                        req_wdata_d = st_data;
                    end
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (ls_q) begin
                        state_d = WAIT;
                    end else begin
                        state_d    = DONE;
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b0;
                        result_d   = '0;
                    end
                end
            end
            WAIT: begin
                if (mem.mem_resp_valid) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    misalign_d = 1'b0;
                    result_d   = ext_data;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any op in flight without a writeback pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ls_q        <= 1'b0;
            code_q      <= 3'b000;
            lo_q        <= 2'b00;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_wstrb_q <= 4'b0000;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            misalign_q  <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            ls_q        <= ls_d;
            code_q      <= code_d;
            lo_q        <= lo_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_wstrb_q <= req_wstrb_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            wb_valid_q  <= wb_valid_d;
            misalign_q  <= misalign_d;
            result_q    <= result_d;
        end
    end

    assign ex_ready          = (state_q == IDLE);
    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_we    = req_we_q;
    assign mem.mem_req_wstrb = req_wstrb_q;
    assign mem.mem_req_addr  = req_addr_q;
    assign mem.mem_req_wdata = req_wdata_q;
    assign wb_valid          = wb_valid_q;
    assign misalign          = misalign_q;
    assign dmem_result       = result_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit with a transaction model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid, ex_ls, ex_signed, ex_h, ex_b;
    logic [31:0] ex_addr, ex_wdata;
    logic        ex_ready, wb_valid, misalign;
    logic [31:0] dmem_result;

    load_store_unit_if #(.WIDTH(32), .ADDR_LEN(32)) mem_if ();

    load_store_unit #(.WIDTH(32), .ADDR_LEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_ls       (ex_ls),
        .ex_signed   (ex_signed),
        .ex_h        (ex_h),
        .ex_b        (ex_b),
        .ex_addr     (ex_addr),
        .ex_wdata    (ex_wdata),
        .mem         (mem_if),
        .wb_valid    (wb_valid),
        .dmem_result (dmem_result),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- reference rules ----------------
    function automatic int op_size(input bit ls, input bit [2:0] code);
        if (ls) begin
            if (code == 3'b000) return 4;
            if (code == 3'b110 || code == 3'b010) return 2;
            if (code == 3'b101 || code == 3'b001) return 1;
            return 0;
        end
        if (code[1:0] == 2'b00) return 4;
        if (code[1:0] == 2'b10) return 2;
        if (code[1:0] == 2'b01) return 1;
        return 0;
    endfunction

    function automatic bit op_rejected(input bit ls, input bit [2:0] code, input logic [31:0] addr);
        int sz = op_size(ls, code);
        return (sz == 0) || ((addr % sz) != 0);
    endfunction

    function automatic logic [31:0] exp_load(input bit [2:0] code, input logic [31:0] addr, input logic [31:0] word);
        int          sz = op_size(1'b1, code);
        logic [31:0] v, mask, sgn;
        if (sz == 4) return word;
        mask = (sz == 1) ? 32'hFF : 32'hFFFF;
        sgn  = (sz == 1) ? 32'h80 : 32'h8000;
        v = (word >> ((addr % 4) * 8)) & mask;
        if (code[2] && ((v & sgn) != 0)) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(input bit ls, input bit [2:0] code, input logic [31:0] addr);
        int sz = op_size(ls, code);
        if (ls) return 4'b0000;
        if (sz == 1) return 4'(1 << (addr % 4));
        if (sz == 2) return 4'(3 << (addr % 4));
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdata(input bit [2:0] code, input logic [31:0] wd);
        int sz = op_size(1'b0, code);
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // ---------------- memory responder ----------------
    bit          cfg_rand  = 1'b0;
    bit          cfg_stray = 1'b0;
    int          cfg_rdy   = 0;
    int          cfg_resp  = 0;
    logic [31:0] cfg_data  = 32'h0;
    int          rdy_cnt   = -1;
    int          resp_cnt  = 0;
    bit          pending   = 1'b0;

    initial begin
        mem_if.mem_req_ready  = 1'b0;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_if.mem_req_ready  = 1'b0;
            mem_if.mem_resp_valid = 1'b0;
            if (pending) begin
                if (resp_cnt == 0) begin
                    mem_if.mem_resp_valid = 1'b1;
                    mem_if.mem_resp_data  = cfg_rand ? $urandom : cfg_data;
                    pending = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end else if (cfg_stray && $urandom_range(0, 3) == 0) begin
                mem_if.mem_resp_valid = 1'b1;
                mem_if.mem_resp_data  = $urandom;
            end
            if (!mem_if.mem_req_valid) begin
                rdy_cnt = -1;
            end else begin
                if (rdy_cnt < 0) rdy_cnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_rdy;
                if (rdy_cnt == 0) begin
                    mem_if.mem_req_ready = 1'b1;
                    rdy_cnt = -1;
                    if (!mem_if.mem_req_we) begin
                        pending  = 1'b1;
                        resp_cnt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_resp;
                    end
                end else begin
                    rdy_cnt--;
                end
            end
        end
    end

    // ---------------- cycle monitor against the transaction model ----------------
    bit          m_busy = 1'b0;
    bit          m_ls, m_rej, m_req_done, m_got, m_due;
    bit [2:0]    m_code;
    logic [31:0] m_addr, m_wd, m_rdata;
    int          m_wb = 0;

    always @(negedge clk) begin
        bit busy0;
        if (rst) begin
            m_busy = 1'b0;
            m_due  = 1'b0;
        end else begin
            busy0 = m_busy;
            check("ex_ready", ex_ready, !m_busy);
            check("req_valid", mem_if.mem_req_valid, m_busy && !m_rej && !m_req_done);
            check("wb_valid", wb_valid, m_due);
            if (m_due && wb_valid) begin
                check("misalign", misalign, m_rej);
                check("dmem_result", dmem_result,
                      (m_rej || !m_ls) ? 32'h0 : exp_load(m_code, m_addr, m_rdata));
                m_wb++;
                m_busy = 1'b0;
                m_due  = 1'b0;
            end else begin
                if (m_busy && m_ls && m_req_done && !m_got && mem_if.mem_resp_valid) begin
                    m_rdata = mem_if.mem_resp_data;
                    m_got   = 1'b1;
                    m_due   = 1'b1;
                end
                if (m_busy && mem_if.mem_req_valid) begin
                    check("req_addr", mem_if.mem_req_addr, m_addr - (m_addr % 4));
                    check("req_we", mem_if.mem_req_we, !m_ls);
                    check("req_wstrb", mem_if.mem_req_wstrb, exp_strb(m_ls, m_code, m_addr));
                    if (!m_ls) check("req_wdata", mem_if.mem_req_wdata, exp_wdata(m_code, m_wd));
                    if (mem_if.mem_req_ready) begin
                        m_req_done = 1'b1;
                        if (!m_ls) m_due = 1'b1;
                    end
                end
            end
            if (!busy0 && ex_valid) begin
                m_busy     = 1'b1;
                m_ls       = ex_ls;
                m_code     = {ex_signed, ex_h, ex_b};
                m_addr     = ex_addr;
                m_wd       = ex_wdata;
                m_rej      = op_rejected(ex_ls, {ex_signed, ex_h, ex_b}, ex_addr);
                m_req_done = 1'b0;
                m_got      = 1'b0;
                m_due      = m_rej;
            end
        end
    end

    // ---------------- driver helpers ----------------
    int n_issued = 0;

    task automatic set_op(input bit ls, input bit [2:0] code, input logic [31:0] addr, input logic [31:0] wd);
        ex_ls = ls;
        {ex_signed, ex_h, ex_b} = code;
        ex_addr  = addr;
        ex_wdata = wd;
        ex_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = ex_ready;
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_in_time", acc, 1'b1);
        n_issued++;
    endtask

    task automatic do_op(input bit ls, input bit [2:0] code, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] res, output logic mis,
                         output logic [31:0] raddr, output logic [3:0] rstrb, output logic [31:0] rwd,
                         output int reqc, output bit stable);
        @(posedge clk);
        #1;
        set_op(ls, code, addr, wd);
        wait_accept();
        ex_valid = 1'b0;
        lat = 0; reqc = 0; stable = 1'b1;
        raddr = 0; rstrb = 0; rwd = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            lat++;
            if (mem_if.mem_req_valid) begin
                if (reqc > 0 && (raddr !== mem_if.mem_req_addr || rstrb !== mem_if.mem_req_wstrb ||
                                 rwd !== mem_if.mem_req_wdata)) stable = 1'b0;
                raddr = mem_if.mem_req_addr;
                rstrb = mem_if.mem_req_wstrb;
                rwd   = mem_if.mem_req_wdata;
                reqc++;
            end
            if (wb_valid) break;
        end
        check("done_in_time", wb_valid, 1'b1);
        res = dmem_result;
        mis = misalign;
        @(negedge clk);
        check("wb_single_pulse", wb_valid, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          lat, reqc, cnt;
        logic [31:0] res, raddr, rwd;
        logic [3:0]  rstrb;
        logic        mis;
        bit          stable;

        ex_valid = 1'b0; ex_ls = 1'b0; ex_signed = 1'b0; ex_h = 1'b0; ex_b = 1'b0;
        ex_addr = 32'h0; ex_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_ex_ready", ex_ready, 1'b1);
        check("rst_req_valid", mem_if.mem_req_valid, 1'b0);
        check("rst_req_we", mem_if.mem_req_we, 1'b0);
        check("rst_wstrb", mem_if.mem_req_wstrb, 4'b0000);
        check("rst_addr", mem_if.mem_req_addr, 32'h0);
        check("rst_wdata", mem_if.mem_req_wdata, 32'h0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_result", dmem_result, 32'h0);

        // signed byte load at the top lane, zero-wait memory
        cfg_rdy = 0; cfg_resp = 0; cfg_data = 32'h80FF_FF12;
        do_op(1'b1, 3'b101, 32'h1003, 32'h0, lat, res, mis, raddr, rstrb, rwd, reqc, stable);
        check("sb_req_addr", raddr, 32'h1000);
        check("sb_result", res, 32'hFFFF_FF80);
        check("sb_latency", lat, 3);
        check("sb_misalign", mis, 1'b0);

        // unsigned half load from the upper half
        cfg_data = 32'hBEEF_1234;
        do_op(1'b1, 3'b010, 32'h2002, 32'h0, lat, res, mis, raddr, rstrb, rwd, reqc, stable);
        check("uh_result", res, 32'h0000_BEEF);
        check("uh_wstrb", rstrb, 4'b0000);

        // misaligned word load never reaches memory
        do_op(1'b1, 3'b000, 32'h4002, 32'h0, lat, res, mis, raddr, rstrb, rwd, reqc, stable);
        check("mis_latency", lat, 1);
        check("mis_flag", mis, 1'b1);
        check("mis_req_cycles", reqc, 0);
        check("mis_result", res, 32'h0);

        // reset while waiting for a load response, then a late response arrives
        cfg_rdy = 0; cfg_resp = 3;
        @(posedge clk);
        #1 set_op(1'b1, 3'b000, 32'h5000, 32'h0);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rstw_wb_valid", wb_valid, 1'b0);
            check("rstw_req_valid", mem_if.mem_req_valid, 1'b0);
            check("rstw_result", dmem_result, 32'h0);
            check("rstw_misalign", misalign, 1'b0);
            check("rstw_ex_ready", ex_ready, 1'b1);
        end
        n_issued--;   // the abandoned load never completes

        // byte store with memory holding off ready for three cycles
        n_issued++;
        cfg_rdy = 3; cfg_resp = 0;
        do_op(1'b0, 3'b001, 32'h3001, 32'h0000_00AB, lat, res, mis, raddr, rstrb, rwd, reqc, stable);
        check("sbst_wdata", rwd, 32'hABAB_ABAB);
        check("sbst_wstrb", rstrb, 4'b0010);
        check("sbst_stable", stable, 1'b1);
        check("sbst_req_cycles", reqc, 4);
        check("sbst_latency", lat, 5);
        check("sbst_result", res, 32'h0);

        // half store, minimum store latency
        cfg_rdy = 0;
        do_op(1'b0, 3'b110, 32'h6002, 32'h1234_CAFE, lat, res, mis, raddr, rstrb, rwd, reqc, stable);
        check("hst_latency", lat, 2);
        check("hst_wdata", rwd, 32'hCAFE_CAFE);
        check("hst_wstrb", rstrb, 4'b1100);

        // back-to-back: second op held valid while the first is in flight
        cfg_rdy = 0; cfg_resp = 0; cfg_data = 32'h1122_3344;
        @(posedge clk);
        #1 set_op(1'b0, 3'b000, 32'h7000, 32'h5555_AAAA);
        wait_accept();
        set_op(1'b1, 3'b001, 32'h7005, 32'h0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ex_ready && cnt < 20);
        check("b2b_ready_cycle", cnt, 3);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        n_issued++;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            lat++;
            if (wb_valid) break;
        end
        check("b2b_load_latency", lat, 3);
        check("b2b_load_result", dmem_result, 32'h0000_0033);

        // randomized traffic with random memory timing and stray responses
        cfg_rand = 1'b1; cfg_stray = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            set_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            wait_accept();
            if ($urandom_range(0, 2) == 0) begin
                ex_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        ex_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("all_ops_written_back", m_wb, n_issued);
        check("final_idle", ex_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
